// File: rtl/rope_frame_sched.sv
// Per-frame rope scheduler: on vertical blank it freezes the pointer as the anchor, runs STEPS
// engine steps, then snapshots node coordinates one per cycle. Optional: ROPE_FRAME_SCHED_OVERRUN_EN.
module rope_frame_sched #(
  parameter int NODES    = 20,
  parameter int COORD_W  = 10,
  parameter int STEPS    = 4,
  parameter int V_ACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       pix_x,
  input  logic [COORD_W-1:0]       pix_y,
  input  logic [COORD_W-1:0]       mouse_x,
  input  logic [COORD_W-1:0]       mouse_y,
  input  logic [NODES*COORD_W-1:0] rope_x,
  input  logic [NODES*COORD_W-1:0] rope_y,
  input  logic                     step_ack,
  output logic                     step_req,
  output logic [COORD_W-1:0]       anchor_x,
  output logic [COORD_W-1:0]       anchor_y,
  output logic [NODES*COORD_W-1:0] disp_x,
  output logic [NODES*COORD_W-1:0] disp_y,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);
  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {IDLE, CAPTURE, STEP, GAP, COPY, DONE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                step_cnt;
  logic [IDX_W-1:0]                node_idx;
  logic                            vbl_cond, vbl_q, vbl_tick;
  logic [NODES-1:0][COORD_W-1:0]   rope_xa, rope_ya, snap_x, snap_y;

  assign vbl_cond = (pix_y == COORD_W'(V_ACTIVE)) && (pix_x == '0);
  assign rope_xa  = rope_x;
  assign rope_ya  = rope_y;
  assign disp_x   = snap_x;
  assign disp_y   = snap_y;

  // vbl_q resets high so a condition already true at reset release does not fire a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      step_cnt   <= '0;
      node_idx   <= '0;
      anchor_x   <= '0;
      anchor_y   <= '0;
      step_req   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      vbl_q      <= 1'b1;
      vbl_tick   <= 1'b0;
    end else begin
      vbl_q    <= vbl_cond;
      vbl_tick <= vbl_cond & ~vbl_q;
      case (state)
        IDLE: if (vbl_tick) begin
          state <= CAPTURE;
          busy  <= 1'b1;
        end
        CAPTURE: begin
          anchor_x <= mouse_x;
          anchor_y <= mouse_y;
          step_cnt <= '0;
          node_idx <= '0;
          step_req <= 1'b1;
          state    <= STEP;
        end
        STEP: if (step_ack) begin
          step_cnt <= step_cnt + 1'b1;
          step_req <= 1'b0;
          state    <= GAP;
        end
        GAP: begin
          if (step_cnt == CNT_W'(STEPS)) begin
            state <= COPY;
          end else begin
            step_req <= 1'b1;
            state    <= STEP;
          end
        end
        COPY: begin
          if (node_idx == IDX_W'(NODES-1)) begin
            node_idx   <= '0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            node_idx <= node_idx + 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One node per COPY cycle; everything else holds so the renderer sees a stable frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_x <= '0;
      snap_y <= '0;
    end else if (state == COPY) begin
      for (int i = 0; i < NODES; i++) begin
        if (node_idx == IDX_W'(i)) begin
          snap_x[i] <= rope_xa[i];
          snap_y[i] <= rope_ya[i];
        end
      end
    end
  end

`ifdef ROPE_FRAME_SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overrun <= 1'b0;
    else if (vbl_tick && state != IDLE)  overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rope_frame_sched.sv
// Bench for rope_frame_sched: a frame-timeline model predicts every output each cycle,
// plus literal checks on latency, anchor freeze, snapshot, overrun and mid-frame reset.
module tb_rope_frame_sched;
  localparam int NODES = 20, W = 10, STEPS = 4, VA = 480;
  typedef logic [NODES*W-1:0] wide_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [W-1:0]      pix_x, pix_y, mouse_x, mouse_y;
  wide_t             rope_x, rope_y;
  logic              step_ack, step_req, busy, frame_done, overrun;
  logic [W-1:0]      anchor_x, anchor_y;
  wide_t             disp_x, disp_y;

  rope_frame_sched #(.NODES(NODES), .COORD_W(W), .STEPS(STEPS), .V_ACTIVE(VA)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .rope_x(rope_x), .rope_y(rope_y), .step_ack(step_ack),
    .step_req(step_req), .anchor_x(anchor_x), .anchor_y(anchor_y), .disp_x(disp_x),
    .disp_y(disp_y), .busy(busy), .frame_done(frame_done), .overrun(overrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int ack_delay = 1, rq = 0;
  logic spur = 1'b0;
  logic exp_ovr_lit;

  // model state (owned by the compare process)
  int    ncyc = 0, m_t0 = 0, m_D = 1;
  logic  m_run = 1'b0, m_ovr = 1'b0, m_condq = 1'b1, m_tick = 1'b0;
  logic [W-1:0] m_ax = '0, m_ay = '0;
  wide_t m_dx = '0, m_dy = '0;
  // measurements of the DUT for the literal checks
  int    busy_first = 0, busy_len = 0, req_hi = 0, done_at = 0, done_cnt = 0;
  logic  busy_prev = 1'b0;

  task automatic chk(string name, wide_t act, wide_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, ncyc, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int k, kc, L, idx;
    logic in_frame, tick, cond, e_req, e_done;
    ncyc++;
    cond = (pix_y == W'(VA)) && (pix_x == '0);
    if (!reset) begin
      m_run = 1'b0; m_ovr = 1'b0; m_ax = '0; m_ay = '0; m_dx = '0; m_dy = '0;
      m_condq = 1'b1; m_tick = 1'b0;
      chk("rst_busy", wide_t'(busy), '0);
      chk("rst_req", wide_t'(step_req), '0);
      chk("rst_done", wide_t'(frame_done), '0);
      chk("rst_ovr", wide_t'(overrun), '0);
      chk("rst_anchor", wide_t'({anchor_x, anchor_y}), '0);
      chk("rst_disp", disp_x | disp_y, '0);
    end else begin
      tick = m_tick;
      k  = ncyc - m_t0;
      kc = 2 + STEPS * (m_D + 1);
      L  = kc + NODES;
      in_frame = m_run && k >= 1 && k <= L;
`ifdef ROPE_FRAME_SCHED_OVERRUN_EN
      if (tick && in_frame) m_ovr = 1'b1;
`endif
      if (tick && !in_frame) begin
        m_run = 1'b1; m_t0 = ncyc; m_D = ack_delay; k = 0;
        kc = 2 + STEPS * (m_D + 1);
        L  = kc + NODES;
      end
      e_req  = in_frame && k >= 2 && k < kc && ((k - 2) % (m_D + 1)) < m_D;
      e_done = in_frame && k == L;
      chk("busy", wide_t'(busy), wide_t'(in_frame));
      chk("step_req", wide_t'(step_req), wide_t'(e_req));
      chk("frame_done", wide_t'(frame_done), wide_t'(e_done));
      chk("overrun", wide_t'(overrun), wide_t'(m_ovr));
      chk("anchor", wide_t'({anchor_x, anchor_y}), wide_t'({m_ax, m_ay}));
      chk("disp_x", disp_x, m_dx);
      chk("disp_y", disp_y, m_dy);
      if (in_frame && k == 1) begin
        m_ax = mouse_x; m_ay = mouse_y;
      end
      if (in_frame && k >= kc && k < L) begin
        idx = k - kc;
        m_dx[idx*W +: W] = rope_x[idx*W +: W];
        m_dy[idx*W +: W] = rope_y[idx*W +: W];
      end
      m_tick  = cond && !m_condq;
      m_condq = cond;
    end
    if (busy && !busy_prev) begin
      busy_first = ncyc; busy_len = 0; req_hi = 0;
    end
    if (busy) begin
      busy_len++;
      if (step_req) req_hi++;
    end
    if (frame_done) begin
      done_at = ncyc; done_cnt++;
    end
    busy_prev = busy;
  end

  task automatic cyc();
    @(posedge clk); #1;
    if (step_req) begin
      rq++;
      step_ack = (rq == ack_delay);
    end else begin
      rq = 0;
      step_ack = spur;
    end
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  // condition true for `hold` cycles starting with the current one
  task automatic vbl(int hold);
    pix_x = '0; pix_y = W'(VA);
    run(hold);
    pix_x = W'(1);
  endtask

  task automatic set_rope(int base);
    for (int i = 0; i < NODES; i++) begin
      rope_x[i*W +: W] = W'(base + 7 * i);
      rope_y[i*W +: W] = W'(base + 500 - 3 * i);
    end
  endtask

  initial begin
    logic got;
`ifdef ROPE_FRAME_SCHED_OVERRUN_EN
    exp_ovr_lit = 1'b1;
`else
    exp_ovr_lit = 1'b0;
`endif
    reset = 1'b1; pix_x = W'(1); pix_y = '0; mouse_x = '0; mouse_y = '0;
    step_ack = 1'b0; set_rope(40);
    #2 reset = 1'b0;
    run(3);
    reset = 1'b1;
    run(3);

    // frame 1: zero-wait acks, anchor freeze, node 7 snapshot
    mouse_x = W'(300); mouse_y = W'(200);
    vbl(1);
    run(3);
    mouse_x = W'(10); mouse_y = W'(10);
    run(9);
    rope_x[7*W +: W] = W'(123);
    run(22);
    chki("f1_anchor_x", int'(anchor_x), 300);
    chki("f1_anchor_y", int'(anchor_y), 200);
    chki("f1_disp7", int'(disp_x[7*W +: W]), 123);
    chki("f1_busy_len", busy_len, 30);
    chki("f1_latency", done_at - busy_first, 29);
    chki("f1_req_hi", req_hi, 4);
    chki("f1_done_cnt", done_cnt, 1);

    // idle: rope moves and spurious acks arrive, snapshot must hold
    set_rope(600);
    spur = 1'b1;
    run(4);
    spur = 1'b0;
    run(4);
    chki("idle_disp7", int'(disp_x[7*W +: W]), 123);
    chki("idle_busy", int'(busy), 0);

    // frame 2: held condition, acks delayed 5 cycles
    ack_delay = 5;
    vbl(3);
    run(50);
    chki("f2_busy_len", busy_len, 46);
    chki("f2_latency", done_at - busy_first, 45);
    chki("f2_req_hi", req_hi, 20);
    chki("f2_done_cnt", done_cnt, 2);
    ack_delay = 1;

    // frame 3: second blank during COPY
    set_rope(200);
    vbl(1);
    run(14);
    vbl(1);
    run(25);
    chki("f3_overrun", int'(overrun), int'(exp_ovr_lit));
    chki("f3_done_cnt", done_cnt, 3);
    chki("f3_idle", int'(busy), 0);

    // frame 4: reset while copying node 10, condition held across release
    vbl(1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      got = busy;
    end
    chki("f4_start_seen", int'(got), 1);
    run(19);
    #1 reset = 1'b0;
    pix_x = '0; pix_y = W'(VA);
    cyc();
    chk("f4_disp_clr", disp_x | disp_y, '0);
    chki("f4_anchor_clr", int'({anchor_x, anchor_y}), 0);
    chki("f4_req_clr", int'(step_req), 0);
    chki("f4_busy_clr", int'(busy), 0);
    run(1);
    reset = 1'b1;
    run(4);
    chki("f4_no_tick_held", int'(busy), 0);
    pix_x = W'(1);
    run(2);

    // frame 5: recovery after reset
    vbl(1);
    run(32);
    chki("f5_done_cnt", done_cnt, 4);
    chki("f5_busy_len", busy_len, 30);
    chki("f5_overrun", int'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
